sram_req_arbiter: RTL
=====================

# sram_req_arbiter

Two-to-one arbiter sharing a single request/acknowledge memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage). It accepts one transaction at a time, latches the winner's request, drives it downstream, and routes the address and data acknowledgements and the read data back to the winning requester. Data requests have priority, with a bounded-streak rule so instruction fetch cannot starve.

## Interface
Parameters:
- DATA_BURST_MAX, 4: maximum consecutive data grants while inst_req is pending; range 1–15.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- resetn  in  1  reset; synchronous, active-low.
- inst_req  in  1  instruction request. inst_wr, inst_size, inst_addr, inst_wstrb and inst_wdata stay stable until inst_addr_ok.
- inst_wr  in  1  write flag (0 for fetch).
- inst_size  in  2  0 = byte, 1 = half, 2 = word.
- inst_addr  in  32  byte address.
- inst_wstrb  in  4  byte enables.
- inst_wdata  in  32  write data.
- inst_addr_ok  out  1  request accepted downstream.
- inst_data_ok  out  1  response returned.
- inst_rdata  out  32  read data, valid with inst_data_ok.
- data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata  in  same widths  data requester, same rules as inst.
- data_addr_ok, data_data_ok  out  1  as for inst.
- data_rdata  out  32  as for inst.
- mem_req  out  1  downstream request.
- mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata  out  1/2/32/4/32  latched request fields.
- mem_addr_ok  in  1  downstream accepted request.
- mem_data_ok  in  1  downstream response.
- mem_rdata  in  32  downstream read data.

## Operation
- State machine: IDLE, REQ, RESP. A 1-bit grant register (0 = inst, 1 = data) and a streak counter (4 bits) complete the state.
- **IDLE**
  - If neither requester is asserting, stay in IDLE.
  - Otherwise pick a winner, latch its wr/size/addr/wstrb/wdata and grant, and go to REQ.
  - Winner selection: data wins unless inst_req=1 and streak==DATA_BURST_MAX, in which case inst wins.
- **Streak counter**, updated on each grant:
  - data grant with inst_req=1: increment, saturating at DATA_BURST_MAX;
  - data grant with inst_req=0: clear to 0;
  - inst grant: clear to 0.
- **REQ**
  - mem_req=1 and mem_* outputs come from the latched fields.
  - On mem_addr_ok: pulse the granted requester's addr_ok combinationally in the same cycle.
  - mem_addr_ok with mem_data_ok in the same cycle: pulse both acks and return to IDLE.
  - mem_addr_ok alone: go to RESP.
- **RESP**
  - mem_req=0.
  - On mem_data_ok: pulse the granted requester's data_ok, drive its rdata from mem_rdata, and return to IDLE.
- **Output routing**
  - The non-granted requester always sees addr_ok=0 and data_ok=0.
  - *_rdata outputs pass mem_rdata through for both requesters; they are meaningful only with data_ok.
  - mem_data_ok in IDLE or REQ without mem_addr_ok is ignored.
- **Reset** (resetn=0 at an edge): state IDLE, grant 0, streak 0, latched fields 0. An in-flight transaction is abandoned; the downstream memory is reset by the same signal.
- **Reset output values:** mem_req=0, all mem_* field outputs 0, all addr_ok/data_ok 0.

## Timing
- Arbitration latency: a request seen in IDLE produces mem_req=1 in the next cycle.
- addr_ok and data_ok to the requesters have zero added latency relative to mem_addr_ok and mem_data_ok.
- Minimum transaction length is 2 cycles (IDLE to REQ with both acks to IDLE).
- Back-to-back throughput: at most one transaction per 2 cycles. The arbiter is never in REQ or RESP on two consecutive transactions without an intervening IDLE cycle.
- Requests arriving while the arbiter is busy are held by their requester and evaluated at the next IDLE cycle.
- Simultaneous inst_req and data_req in IDLE resolve in that same cycle per the streak rule.
- Latched fields are frozen from the grant edge until return to IDLE, even if requester inputs change.

## Test plan
- Single fetch:
  - Stimulus: inst_req, addr 0x1C000000; memory acks addr_ok one cycle after mem_req, then data_ok with rdata 0x02800000 two cycles later.
  - Required: mem_addr=0x1C000000; inst_addr_ok and inst_data_ok each pulse once; inst_rdata=0x02800000; data_* acks stay 0.
- Simultaneous request:
  - Stimulus: inst_req and data_req (word write to 0x1C001000, wstrb 0xF) asserted together.
  - Required: data granted first with mem_wr=1, mem_wstrb=0xF; inst granted on the next IDLE.
- Starvation bound:
  - Stimulus: inst_req and data_req held high continuously, DATA_BURST_MAX=4.
  - Required: grant sequence is D, D, D, D, I, D, D, D, D, I, …
- Combined ack:
  - Stimulus: memory asserts mem_addr_ok and mem_data_ok in the same cycle.
  - Required: both acks pulse to the granted requester in that cycle; state is IDLE next cycle; next mem_req no earlier than 2 cycles later.
- Input change after grant:
  - Stimulus: data_addr changes from 0x100 to 0x200 while in REQ with addr_ok withheld for 3 cycles.
  - Required: mem_addr stays 0x100 throughout.
- Reset mid-transaction:
  - Stimulus: resetn=0 for one edge while in RESP.
  - Required: next cycle mem_req=0, all acks 0, state IDLE, streak 0; a subsequent fetch completes normally.

Source files
------------

// File: rtl/sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_req_arbiter
// Purpose  : 2:1 arbiter sharing one req/ack memory port between the IF stage
//            and the MEM stage. Data wins, but a bounded streak protects fetch.
// Revision : 1.0 - initial release
// ============================================================================
module sram_req_arbiter #(
   parameter int DATA_BURST_MAX = 4
) (
   input  logic        clk,
   input  logic        resetn,
   // instruction requester
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   // data requester
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   // downstream memory port
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [3:0] c_burst_max = 4'(DATA_BURST_MAX);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_grant;      // 0 = inst, 1 = data
   logic [3:0]  r_streak;
   logic        r_wr;
   logic [1:0]  r_size;
   logic [31:0] r_addr;
   logic [3:0]  r_wstrb;
   logic [31:0] r_wdata;

   logic        w_any_req;
   logic        w_pick_data;
   logic        w_ack_addr;
   logic        w_ack_data;

   always_comb begin
      w_any_req   = inst_req | data_req;
      // data loses only when fetch is waiting and the streak has run out
      w_pick_data = data_req & ~(inst_req & (r_streak == c_burst_max));
      w_ack_addr  = 1'b0;
      w_ack_data  = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) w_state_nxt = S_REQ;
         end
         S_REQ: begin
            if (mem_addr_ok) begin
               w_ack_addr = 1'b1;
               if (mem_data_ok) begin
                  w_ack_data  = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_RESP;
               end
            end
         end
         S_RESP: begin
            if (mem_data_ok) begin
               w_ack_data  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state  <= S_IDLE;
         r_grant  <= 1'b0;
         r_streak <= 4'd0;
         r_wr     <= 1'b0;
         r_size   <= 2'd0;
         r_addr   <= 32'd0;
         r_wstrb  <= 4'd0;
         r_wdata  <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == S_IDLE) && w_any_req) begin
            r_grant <= w_pick_data;
            if (w_pick_data) begin
               r_wr    <= data_wr;
               r_size  <= data_size;
               r_addr  <= data_addr;
               r_wstrb <= data_wstrb;
               r_wdata <= data_wdata;
               if (!inst_req)
                  r_streak <= 4'd0;
               else if (r_streak != c_burst_max)
                  r_streak <= r_streak + 4'd1;
            end else begin
               r_wr     <= inst_wr;
               r_size   <= inst_size;
               r_addr   <= inst_addr;
               r_wstrb  <= inst_wstrb;
               r_wdata  <= inst_wdata;
               r_streak <= 4'd0;
            end
         end
      end
   end

   assign mem_req   = (r_state == S_REQ);
   assign mem_wr    = r_wr;
   assign mem_size  = r_size;
   assign mem_addr  = r_addr;
   assign mem_wstrb = r_wstrb;
   assign mem_wdata = r_wdata;

   assign inst_addr_ok = w_ack_addr & ~r_grant;
   assign inst_data_ok = w_ack_data & ~r_grant;
   assign data_addr_ok = w_ack_addr &  r_grant;
   assign data_data_ok = w_ack_data &  r_grant;
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

endmodule
`default_nettype wire
